frame_commit: RTL

Commits the next-state frame that the cell-update engine has built in the next-state RAM into the display VRAM. It reads each cell of the next-state RAM, writes it into VRAM, and optionally clears the RAM cell so the next update pass starts empty. It runs between update passes: the top level pulses `start_i` after the update engine's `done_o`, and waits for this block's `done_o` before starting the next pass. It also reports the number of occupied cells in the committed frame.

---
 rtl/frame_commit_if.sv | 37 +++
 rtl/frame_commit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/frame_commit_if.sv
// Memory-side bus of frame_commit: next-state RAM read and clear ports plus the VRAM write port.
// master = frame_commit, slave = the RAM/VRAM wrapper.
interface frame_commit_if #(
    parameter int unsigned ADDR_WIDTH = 19,
    parameter int unsigned DATA_WIDTH = 2
);
    logic [ADDR_WIDTH-1:0] ram_rd_address_o;
    logic [DATA_WIDTH-1:0] ram_rd_data_i;
    logic [ADDR_WIDTH-1:0] ram_wr_address_o;
    logic [DATA_WIDTH-1:0] ram_wr_data_o;
    logic                  ram_wr_en_o;
    logic [ADDR_WIDTH-1:0] vram_wr_address_o;
    logic [DATA_WIDTH-1:0] vram_wr_data_o;
    logic                  vram_wr_en_o;

    modport master (
        output ram_rd_address_o,
        input  ram_rd_data_i,
        output ram_wr_address_o,
        output ram_wr_data_o,
        output ram_wr_en_o,
        output vram_wr_address_o,
        output vram_wr_data_o,
        output vram_wr_en_o
    );

    modport slave (
        input  ram_rd_address_o,
        output ram_rd_data_i,
        input  ram_wr_address_o,
        input  ram_wr_data_o,
        input  ram_wr_en_o,
        input  vram_wr_address_o,
        input  vram_wr_data_o,
        input  vram_wr_en_o
    );
endinterface

// File: rtl/frame_commit.sv
// Copies the next-state RAM into VRAM one cell per cycle and counts occupied cells.
// Define FRAME_COMMIT_CLEAR_EN to also zero each RAM cell as it is copied.
module frame_commit #(
    parameter int unsigned ACTIVE_COLUMNS = 640,
    parameter int unsigned ACTIVE_ROWS    = 480,
    parameter int unsigned DATA_WIDTH     = 2,
    localparam int unsigned ADDR_WIDTH    = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    frame_commit_if.master        mem_if,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] pixel_count_o
);

    localparam int unsigned NUM_CELLS = ACTIVE_COLUMNS * ACTIVE_ROWS;
    localparam logic [ADDR_WIDTH-1:0] CELL_END  = ADDR_WIDTH'(NUM_CELLS);
    localparam logic [ADDR_WIDTH-1:0] LAST_CELL = ADDR_WIDTH'(NUM_CELLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_COPY = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] pixel_count_q, pixel_count_d;
    logic                  last_cell_c;
    logic                  cell_nz_c;

    assign last_cell_c   = (wr_ptr_q == LAST_CELL);
    assign cell_nz_c     = |mem_if.ram_rd_data_i;
    assign pixel_count_o = pixel_count_q;

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_READ;
            S_READ:  state_d = S_COPY;
            S_COPY:  if (last_cell_c) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs and datapath next values; every port idles at zero
    always_comb begin
        busy_o                   = 1'b1;
        done_o                   = 1'b0;
        mem_if.ram_rd_address_o  = '0;
        mem_if.ram_wr_address_o  = '0;
        mem_if.ram_wr_data_o     = '0;
        mem_if.ram_wr_en_o       = 1'b0;
        mem_if.vram_wr_address_o = '0;
        mem_if.vram_wr_data_o    = '0;
        mem_if.vram_wr_en_o      = 1'b0;
        rd_ptr_d                 = rd_ptr_q;
        wr_ptr_d                 = wr_ptr_q;
        count_d                  = count_q;
        pixel_count_d            = pixel_count_q;

        case (state_q)
            S_IDLE: begin
                busy_o   = 1'b0;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                count_d  = '0;
            end
            S_READ: begin
                mem_if.ram_rd_address_o = rd_ptr_q;
                rd_ptr_d                = ADDR_WIDTH'(1);
            end
            S_COPY: begin
                mem_if.vram_wr_address_o = wr_ptr_q;
                mem_if.vram_wr_data_o    = mem_if.ram_rd_data_i;
                mem_if.vram_wr_en_o      = 1'b1;
`ifdef FRAME_COMMIT_CLEAR_EN
                mem_if.ram_wr_address_o  = wr_ptr_q;
                mem_if.ram_wr_data_o     = '0;
                mem_if.ram_wr_en_o       = 1'b1;
`else
                mem_if.ram_wr_address_o  = '0;
                mem_if.ram_wr_data_o     = '0;
                mem_if.ram_wr_en_o       = 1'b0;
`endif
                // Read runs one cell ahead of the write and stops once every cell is fetched
                if (rd_ptr_q < CELL_END) begin
                    mem_if.ram_rd_address_o = rd_ptr_q;
                    rd_ptr_d                = rd_ptr_q + ADDR_WIDTH'(1);
                end
                count_d = count_q + ADDR_WIDTH'(cell_nz_c);
                if (last_cell_c) begin
                    pixel_count_d = count_d;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
                end
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            pixel_count_q <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            pixel_count_q <= pixel_count_d;
        end
    end

endmodule
